// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate engine: logical/arithmetic shifts and rotates
// applied up to STEP bit positions per cycle, with valid/ready on both sides.
module shift_rotate_unit #(
  parameter int WIDTH = 20,
  parameter int AMT_W = 5,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and a held result stays stable.

  localparam int AW1 = AMT_W + 1;
  localparam logic [AW1-1:0] WIDTH_V = AW1'(WIDTH);
  localparam logic [AW1-1:0] STEP_V  = AW1'(STEP);

  localparam logic [2:0] M_SHR = 3'b000;
  localparam logic [2:0] M_SHL = 3'b001;
  localparam logic [2:0] M_ROR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ASR = 3'b100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       mode_q, mode_d;
  logic [AW1-1:0]   rem_q, rem_d;
  logic             err_q, err_d;

  logic [AW1-1:0]   k;
  logic [AW1-1:0]   amt_x;
  logic [WIDTH-1:0] asr_v;
  logic [WIDTH-1:0] step_v;
  logic             legal;

  always_comb begin
    k      = (rem_q < STEP_V) ? rem_q : STEP_V;
    amt_x  = {1'b0, in_amount};
    legal  = (in_mode <= M_ASR);
    asr_v  = $signed(data_q) >>> k;
    // k is at most rem_q < WIDTH inside BUSY, so WIDTH-k is never zero
    case (mode_q)
      M_SHR:   step_v = data_q >> k;
      M_SHL:   step_v = data_q << k;
      M_ROR:   step_v = (data_q >> k) | (data_q << (WIDTH_V - k));
      M_ROL:   step_v = (data_q << k) | (data_q >> (WIDTH_V - k));
      M_ASR:   step_v = asr_v;
      default: step_v = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    res_d   = res_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d = in_mode;
          err_d  = !legal;
          data_d = in_data;
          rem_d  = '0;
          if (legal) begin
            if (in_mode == M_ROR || in_mode == M_ROL) begin
              rem_d = amt_x % WIDTH_V;
            end else if (amt_x >= WIDTH_V) begin
              data_d = (in_mode == M_ASR) ? {WIDTH{in_data[WIDTH-1]}} : '0;
            end else begin
              rem_d = amt_x;
            end
          end
          if (rem_d != '0) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            res_d   = data_d;
          end
        end
      end
      BUSY: begin
        data_d = step_v;
        rem_d  = rem_q - k;
        if (rem_d == '0) begin
          state_d = DONE;
          res_d   = data_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      res_q   <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit: vector table for results and latency,
// plus hand sequences for backpressure, reserved mode and mid-operation reset.
module tb_shift_rotate_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic [4:0]  in_amount = '0;
  logic [2:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_data;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  shift_rotate_unit #(.WIDTH(20), .AMT_W(5), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amount(in_amount), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] data;
    logic [4:0]  amt;
    logic [2:0]  mode;
    logic [19:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [19:0] d, input logic [4:0] a, input logic [2:0] m);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("req_ready_timeout", {31'b0, in_ready}, 1);
    in_data = d;
    in_amount = a;
    in_mode = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("retire_valid", {31'b0, out_valid}, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic saw_valid;

    //            data      amt  mode    exp_data  err lat
    vecs[0]  = '{20'h00001, 5'd1,  3'b010, 20'h80000, 1'b0, 2};
    vecs[1]  = '{20'h80001, 5'd4,  3'b011, 20'h00018, 1'b0, 2};
    vecs[2]  = '{20'h12345, 5'd20, 3'b010, 20'h12345, 1'b0, 1};
    vecs[3]  = '{20'h00001, 5'd5,  3'b001, 20'h00020, 1'b0, 3};
    vecs[4]  = '{20'hF0000, 5'd19, 3'b000, 20'h00001, 1'b0, 6};
    vecs[5]  = '{20'h80000, 5'd25, 3'b100, 20'hFFFFF, 1'b0, 1};
    vecs[6]  = '{20'h80000, 5'd3,  3'b100, 20'hF0000, 1'b0, 2};
    vecs[7]  = '{20'hFFFFF, 5'd20, 3'b001, 20'h00000, 1'b0, 1};
    vecs[8]  = '{20'hABCDE, 5'd7,  3'b110, 20'hABCDE, 1'b1, 1};
    vecs[9]  = '{20'h00010, 5'd4,  3'b000, 20'h00001, 1'b0, 2};
    vecs[10] = '{20'h00001, 5'd31, 3'b011, 20'h00800, 1'b0, 4};
    vecs[11] = '{20'h00003, 5'd0,  3'b010, 20'h00003, 1'b0, 1};
    vecs[12] = '{20'h40000, 5'd2,  3'b100, 20'h10000, 1'b0, 2};
    vecs[13] = '{20'hFFFFF, 5'd16, 3'b000, 20'h0000F, 1'b0, 5};

    #12;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {12'b0, out_data}, 0);
    check("rst_out_err", {31'b0, out_err}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      send_req(vecs[i].data, vecs[i].amt, vecs[i].mode);
      wait_result(lat);
      check($sformatf("v%0d_data", i), {12'b0, out_data}, {12'b0, vecs[i].exp_data});
      check($sformatf("v%0d_err", i), {31'b0, out_err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      retire();
    end

    // Backpressure: hold result with out_ready low while in_valid pulses
    send_req(20'h00001, 5'd5, 3'b001);
    wait_result(lat);
    check("bp_lat", lat, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_data = 20'h55555;
      in_amount = 5'd1;
      in_mode = 3'b000;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_valid", i), {31'b0, out_valid}, 1);
      check($sformatf("bp%0d_data", i), {12'b0, out_data}, 32'h20);
      check($sformatf("bp%0d_err", i), {31'b0, out_err}, 0);
      check($sformatf("bp%0d_in_ready", i), {31'b0, in_ready}, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 20'h00010;
    in_amount = 5'd4;
    in_mode = 3'b000;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_retire_valid", {31'b0, out_valid}, 0);
    check("bp_retire_in_ready", {31'b0, in_ready}, 1);
    check("bp_retire_busy", {31'b0, busy}, 0);
    check("bp_retire_data_kept", {12'b0, out_data}, 32'h20);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accept_busy", {31'b0, busy}, 1);
    wait_result(lat);
    check("bp_next_lat", lat, 2);
    check("bp_next_data", {12'b0, out_data}, 32'h1);
    retire();

    // Reset in the second BUSY cycle discards the operation
    send_req(20'hFFFFF, 5'd16, 3'b000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'b0, in_ready}, 1);
    check("mid_rst_out_valid", {31'b0, out_valid}, 0);
    check("mid_rst_out_data", {12'b0, out_data}, 0);
    check("mid_rst_out_err", {31'b0, out_err}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_valid", {31'b0, saw_valid}, 0);
    send_req(20'h00001, 5'd5, 3'b001);
    wait_result(lat);
    check("post_rst_lat", lat, 3);
    check("post_rst_data", {12'b0, out_data}, 32'h20);
    retire();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
